// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared states, reset level and bus widths for the boot ROM loader
package rom_loader_pkg;

  localparam logic RST          = 1'b1;
  localparam int   MEM_ADDR_BUS = 32;
  localparam int   BYTE_BUS     = 8;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_t;

  // States in which the loader is consuming the frame
  function automatic logic ld_busy(ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// rtl/rom_loader_timeout.sv - inter-byte idle watchdog, reloaded on every accepted byte
module rom_loader_timeout
  import rom_loader_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Counts remaining idle cycles; reaching zero means TIMEOUT idle cycles have been consumed
  localparam logic [31:0] RELOAD = 32'(TIMEOUT - 1);

  logic [31:0] remain;

  always_ff @(posedge clk) begin
    if (rst == RST) begin
      remain <= RELOAD;
    end else if (load) begin
      remain <= RELOAD;
    end else if (en && (remain != 32'd0)) begin
      remain <= remain - 32'd1;
    end
  end

  assign expired = (remain == 32'd0);

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte-stream loader into instruction memory with length/checksum check
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          MEM_SIZE  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [BYTE_BUS-1:0]     byte_i,
  input  logic                    byte_valid_i,
  output logic                    byte_ready_o,
  output logic                    we_o,
  output logic [MEM_ADDR_BUS-1:0] waddr_o,
  output logic [BYTE_BUS-1:0]     wdata_o,
  output logic                    cpu_hold_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [31:0]             len_o
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  ld_state_t                state, state_nxt;
  logic [31:0]              len_r;
  logic [31:0]              cnt;
  logic [BYTE_BUS-1:0]      sum;
  logic [1:0]               len_idx;
  logic                     we_r;
  logic [MEM_ADDR_BUS-1:0]  waddr_r;
  logic [BYTE_BUS-1:0]      wdata_r;
  logic [31:0]              len_shift;
  logic                     accept;
  logic                     begin_load;
  logic                     tmo_expired;

  assign accept     = byte_valid_i && byte_ready_o;
  assign begin_load = start_i && !ld_busy(state);
  assign len_shift  = {len_r[23:0], byte_i};

  // Handshake and status are decodes of the state register only
  assign byte_ready_o = ld_busy(state);
  assign cpu_hold_o   = ld_busy(state) || (state == LD_ERR);
  assign done_o       = (state == LD_DONE);
  assign err_o        = (state == LD_ERR);
  assign we_o         = we_r;
  assign waddr_o      = waddr_r;
  assign wdata_o      = wdata_r;
  assign len_o        = len_r;

  rom_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (begin_load || accept),
    .en      (ld_busy(state)),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst == RST) begin
      state <= LD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start_i) state_nxt = LD_LEN;
      end
      LD_LEN: begin
        if (accept) begin
          if (len_idx == 2'd3) begin
            if (len_shift > MEM_LIMIT)      state_nxt = LD_ERR;
            else if (len_shift == 32'd0)    state_nxt = LD_CSUM;
            else                            state_nxt = LD_DATA;
          end
        end else if (tmo_expired) begin
          state_nxt = LD_ERR;
        end
      end
      LD_DATA: begin
        if (accept) begin
          if (cnt == len_r - 32'd1) state_nxt = LD_CSUM;
        end else if (tmo_expired) begin
          state_nxt = LD_ERR;
        end
      end
      LD_CSUM: begin
        if (accept) begin
          state_nxt = (byte_i == sum) ? LD_DONE : LD_ERR;
        end else if (tmo_expired) begin
          state_nxt = LD_ERR;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST) begin
      len_r   <= 32'd0;
      cnt     <= 32'd0;
      sum     <= '0;
      len_idx <= 2'd0;
      we_r    <= 1'b0;
      waddr_r <= BASE_ADDR;
      wdata_r <= '0;
    end else begin
      we_r <= 1'b0;
      if (begin_load) begin
        len_r   <= 32'd0;
        cnt     <= 32'd0;
        sum     <= '0;
        len_idx <= 2'd0;
      end else if (accept) begin
        case (state)
          LD_LEN: begin
            len_r   <= len_shift;
            len_idx <= len_idx + 2'd1;
          end
          LD_DATA: begin
            we_r    <= 1'b1;
            waddr_r <= BASE_ADDR + cnt;
            wdata_r <= byte_i;
            cnt     <= cnt + 32'd1;
            sum     <= sum + byte_i;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed table-driven bench for rom_loader
module tb_rom_loader;

  localparam int          MEM_SIZE = 4096;
  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam int          TMO      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [7:0]  wdata_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] len_o;

  rom_loader #(
    .MEM_SIZE  (MEM_SIZE),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .len_o        (len_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  mem [0:MEM_SIZE-1];

  always @(negedge clk) begin
    if (we_o) begin
      wr_addr.push_back(waddr_o);
      wr_data.push_back(wdata_o);
      wr_cyc.push_back(cyc);
      if ((waddr_o >= BASE) && (waddr_o - BASE < MEM_SIZE)) mem[int'(waddr_o - BASE)] = wdata_o;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready_o) begin
        step();
        ok = 1'b1;
      end
    end
    byte_valid_i = 1'b0;
    if (!ok) begin
      n_chk++;
      n_bad++;
      $display("FAIL send_byte: byte %h not accepted within budget, got ready=0 expected ready=1", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  typedef struct {
    logic [31:0] len_f;
    int          npay;
    logic [63:0] pay;
    bit          send_cs;
    logic [7:0]  cs;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(logic [31:0] l, int n, logic [63:0] p, bit sc, logic [7:0] c,
                              bit d, bit e, int w);
    vec_t v;
    v.len_f = l; v.npay = n; v.pay = p; v.send_cs = sc; v.cs = c;
    v.exp_done = d; v.exp_err = e; v.exp_wr = w;
    return v;
  endfunction

  function automatic logic [7:0] pay_byte(logic [63:0] p, int k);
    return p[63-8*k -: 8];
  endfunction

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] img [0:7];
    logic [7:0] s;
    bit         b2b;
    int         bad_cnt;

    vecs[0] = mk(32'd4,    4, 64'h1300_0000_0000_0000, 1, 8'h13, 1, 0, 4);
    vecs[1] = mk(32'd4,    4, 64'h1300_0000_0000_0000, 1, 8'h14, 0, 1, 4);
    vecs[2] = mk(32'h1001, 0, 64'h0,                   0, 8'h00, 0, 1, 0);
    vecs[3] = mk(32'd0,    0, 64'h0,                   1, 8'h00, 1, 0, 0);
    vecs[4] = mk(32'd0,    0, 64'h0,                   1, 8'h01, 0, 1, 0);
    vecs[5] = mk(32'd8,    8, 64'h0102_0304_0506_0708, 1, 8'h24, 1, 0, 8);
    vecs[6] = mk(32'd3,    3, 64'hFFFF_0200_0000_0000, 1, 8'h00, 1, 0, 3);
    vecs[7] = mk(32'd1,    1, 64'h5A00_0000_0000_0000, 1, 8'h5A, 1, 0, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst ready", byte_ready_o, 0);
    chk("rst hold",  cpu_hold_o, 0);
    chk("rst done",  done_o, 0);
    chk("rst err",   err_o, 0);
    chk("rst we",    we_o, 0);
    chk("rst len",   len_o, 0);
    chk("rst waddr", waddr_o, BASE);
    chk("rst wdata", wdata_o, 0);
    step();

    foreach (vecs[i]) begin
      clear_log();
      pulse_start();
      chk($sformatf("v%0d hold_loading", i), cpu_hold_o, 1);
      chk($sformatf("v%0d ready_loading", i), byte_ready_o, 1);
      send_word(vecs[i].len_f);
      for (int k = 0; k < vecs[i].npay; k++) send_byte(pay_byte(vecs[i].pay, k));
      if (vecs[i].send_cs) send_byte(vecs[i].cs);
      step();
      step();
      @(negedge clk);
      chk($sformatf("v%0d done", i),  done_o, 32'(vecs[i].exp_done));
      chk($sformatf("v%0d err", i),   err_o, 32'(vecs[i].exp_err));
      chk($sformatf("v%0d hold", i),  cpu_hold_o, 32'(vecs[i].exp_err));
      chk($sformatf("v%0d ready", i), byte_ready_o, 0);
      chk($sformatf("v%0d len", i),   len_o, vecs[i].len_f);
      chk($sformatf("v%0d wr_count", i), wr_addr.size(), vecs[i].exp_wr);
      for (int k = 0; k < wr_addr.size() && k < 8; k++) begin
        chk($sformatf("v%0d wr_addr%0d", i, k), wr_addr[k], BASE + k);
        chk($sformatf("v%0d wr_data%0d", i, k), wr_data[k], pay_byte(vecs[i].pay, k));
      end
      if (wr_cyc.size() > 1) begin
        b2b = 1'b1;
        for (int k = 1; k < wr_cyc.size(); k++) if (wr_cyc[k] - wr_cyc[k-1] != 1) b2b = 1'b0;
        chk($sformatf("v%0d back_to_back", i), 32'(b2b), 1);
      end
      if (i == 0) chk("v0 mem_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h1300_0000);
      step();
    end

    // Random valid gaps up to TIMEOUT-1 idle cycles
    clear_log();
    s = 8'h00;
    for (int k = 0; k < 8; k++) begin
      img[k] = 8'(k * 37 + 5);
      s = s + img[k];
    end
    pulse_start();
    repeat ($urandom_range(0, 15)) step();
    send_word(32'd8);
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 3) ? 15 : $urandom_range(0, 15)) step();
      send_byte(img[k]);
    end
    repeat (15) step();
    send_byte(s);
    step();
    @(negedge clk);
    chk("gap done", done_o, 1);
    chk("gap wr_count", wr_addr.size(), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("gap mem%0d", k), mem[k], img[k]);

    // Idle gap of exactly TIMEOUT cycles mid-DATA
    pulse_start();
    send_word(32'd4);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO - 1) step();
    @(negedge clk);
    chk("tmo err_before", err_o, 0);
    chk("tmo ready_before", byte_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    chk("tmo err_at_expiry", err_o, 1);
    chk("tmo hold_at_expiry", cpu_hold_o, 1);
    chk("tmo ready_at_expiry", byte_ready_o, 0);
    step();

    // Reset mid-DATA, then a clean reload with a stray start during LEN
    pulse_start();
    send_word(32'd8);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst hold", cpu_hold_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst err", err_o, 0);
    chk("midrst ready", byte_ready_o, 0);
    chk("midrst len", len_o, 0);
    chk("midrst we", we_o, 0);
    step();
    clear_log();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'h0E);
    step();
    @(negedge clk);
    chk("reload done", done_o, 1);
    chk("reload len", len_o, 4);
    chk("reload wr_count", wr_addr.size(), 4);
    chk("reload mem_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hAABB_CCDD);

    // Maximum length image
    clear_log();
    pulse_start();
    send_word(32'(MEM_SIZE));
    for (int k = 0; k < MEM_SIZE; k++) send_byte(8'(k));
    send_byte(8'h00);
    step();
    @(negedge clk);
    chk("max done", done_o, 1);
    chk("max err", err_o, 0);
    chk("max wr_count", wr_addr.size(), MEM_SIZE);
    bad_cnt = 0;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== BASE + k || wr_data[k] !== 8'(k)) bad_cnt++;
    chk("max image_errors", bad_cnt, 0);
    if (wr_addr.size() > 0) chk("max last_addr", wr_addr[wr_addr.size()-1], BASE + MEM_SIZE - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
Boot-time writer for the byte-wide instruction memory that the fetch path reads.
- Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Writes the payload sequentially into instruction memory and holds the core while loading.
- Verifies length and checksum, then reports done or error.

Parameters:
MEM_SIZE, 4096, instruction memory size in bytes; payload length limit.
BASE_ADDR, 32'h0000_0000, byte address of the first payload byte.
TIMEOUT, 1_000_000, maximum idle cycles between accepted bytes while loading before error.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start_i  input  1  one-cycle pulse that begins a load; ignored while busy
byte_i  input  8  stream data byte
byte_valid_i  input  1  byte_i is valid
byte_ready_o  output  1  loader accepts the byte this cycle
we_o  output  1  memory byte write strobe
waddr_o  output  32  memory byte address
wdata_o  output  8  memory write byte
cpu_hold_o  output  1  holds the core in reset/stall while loading
done_o  output  1  load completed with a good checksum (level)
err_o  output  1  load failed (level)
len_o  output  32  length field of the current/last frame

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values (when rst == 1 at a clk edge):
  - state = IDLE.
  - All outputs 0, except waddr_o = BASE_ADDR.
- Frame format, all fields MSB-first:
  - 4-byte length L.
  - L payload bytes.
  - 1 checksum byte C, where C == (sum of payload bytes) mod 256.
- Byte order: payload byte k is written to BASE_ADDR+k. Each instruction must therefore be sent most-significant byte first, matching the fetch side's big-endian word assembly.
- Handshake:
  - A byte is accepted on a clk edge where byte_valid_i && byte_ready_o.
  - byte_ready_o = 1 only in states LEN, DATA and CSUM; it is a registered state decode with no combinational path from byte_valid_i.
- States:
  - IDLE: cpu_hold_o=0. start_i -> LEN; clears the length shifter, byte counter, checksum accumulator and timeout counter, and sets done_o=err_o=0.
  - LEN: shift accepted bytes into len (len = {len[23:0], byte}). After the 4th byte:
    - L > MEM_SIZE -> ERR.
    - L == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: each accepted byte is written to memory and added to the checksum (8-bit, wraps). When the byte counter reaches L-1 and that byte is accepted -> CSUM.
  - CSUM: accepted byte == sum -> DONE (done_o=1); otherwise -> ERR (err_o=1).
  - DONE / ERR: cpu_hold_o=0 in DONE and 1 in ERR (the core must not run a partial image). start_i -> LEN (re-load).
- cpu_hold_o = 1 in LEN, DATA, CSUM and ERR.
- Write timing:
  - we_o is registered and is a one-cycle pulse in the cycle after acceptance.
  - waddr_o = BASE_ADDR + index, wdata_o = the accepted byte; both are stable while we_o=1.
  - Back-to-back accepted bytes produce back-to-back we_o pulses: one byte per cycle sustained.
- Timeout:
  - A counter runs in LEN, DATA and CSUM and resets on every accepted byte.
  - Reaching TIMEOUT -> ERR.
- start_i in LEN, DATA or CSUM is ignored.
- rst mid-load: the loader returns to IDLE immediately and cpu_hold_o drops next cycle. Partially written memory is not cleared.
- Width rules:
  - The byte counter is 32 bits and compared against L.
  - Address = BASE_ADDR + counter, 32-bit add with no wrap check needed, because L ≤ MEM_SIZE.

Decomposition:
- Shared defines header:
  - State encodings: LD_IDLE, LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERR (3-bit).
  - Reuse the existing RST level and the MEM_ADDR_BUS / BYTE_BUS width macros.
- One natural sub-module: rom_loader_timeout, a loadable down-counter with clear-on-byte and an expire flag.
- FSM, shifter and datapath stay in rom_loader.

Test Plan:
1. Basic load: start; stream 00 00 00 04, 13 00 00 00, C=0x13 -> four we_o pulses at addresses 0..3 with data 13,00,00,00; done_o=1; cpu_hold_o 1 during the load then 0; the memory word at 0 reads 0x13000000.
2. Bad checksum: same frame with C=0x14 -> err_o=1, done_o=0, cpu_hold_o stays 1, four writes still occurred.
3. Oversize: length 00 00 10 01 (4097) with MEM_SIZE=4096 -> ERR right after the 4th length byte, no we_o, byte_ready_o=0.
4. Zero length: 00 00 00 00 then C=00 -> DONE with no writes; C=01 -> ERR.
5. Backpressure and gaps: byte_valid_i toggling randomly with TIMEOUT=16 and gaps ≤ 15 cycles -> DONE and a correct image. A gap of 16 cycles mid-DATA -> ERR exactly at expiry.
6. Reset mid-DATA: assert rst after 2 of 8 payload bytes -> next cycle IDLE, cpu_hold_o=0, all flags 0. Then start with a valid frame -> DONE; start_i pulsed during LEN is ignored.
